// File: rtl/conv_1d_pkg.sv
// Shared types and default geometry for the 1-D convolution line packer.
package conv_1d_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int IMG_W_DEF      = 32;
    localparam int IMG_D_DEF      = 8;

    localparam int COL_BITS  = DATA_WIDTH_DEF * IMG_D_DEF;
    localparam int LINE_BITS = COL_BITS * IMG_W_DEF;

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL
    } bank_state_t;

endpackage

// File: rtl/conv_line_packer_1d_if.sv
// Pixel-column input stream and packed-line output stream of the line packer.
interface conv_line_packer_1d_if #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W      = 32,
    parameter int IMG_D      = 8
);
    localparam int COL_W  = DATA_WIDTH * IMG_D;
    localparam int LINE_W = COL_W * IMG_W;

    logic              pix_valid;
    logic              pix_ready;
    logic [COL_W-1:0]  pix_data;
    logic              pix_last;
    logic [7:0]        opaque_in;
    logic              line_valid;
    logic              line_ready;
    logic [LINE_W-1:0] line_data;
    logic [7:0]        opaque_out;

    modport master (
        output pix_valid, pix_data, pix_last, opaque_in, line_ready,
        input  pix_ready, line_valid, line_data, opaque_out
    );

    modport slave (
        input  pix_valid, pix_data, pix_last, opaque_in, line_ready,
        output pix_ready, line_valid, line_data, opaque_out
    );

endinterface

// File: rtl/conv_line_bank.sv
// One line buffer bank: column-addressed line register, tag, fill state.
// CONV_LINE_PACKER_ZERO_PAD_EN adds a stored column count that zero-masks unfilled columns.
module conv_line_bank
    import conv_1d_pkg::*;
#(
    parameter  int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter  int IMG_W          = IMG_W_DEF,
    parameter  int IMG_D          = IMG_D_DEF,
    localparam int COL_ADDR_WIDTH = $clog2(IMG_W),
    localparam int COL_W          = DATA_WIDTH * IMG_D,
    localparam int LINE_W         = COL_W * IMG_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic [COL_ADDR_WIDTH-1:0] wr_col,
    input  logic [COL_W-1:0]          wr_data,
    input  logic [7:0]                tag_in,
    input  logic                      wr_close,
    input  logic                      rd_free,
    output bank_state_t               state,
    output logic [LINE_W-1:0]         line_out,
    output logic [7:0]                tag_out
);

    bank_state_t       state_q, state_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [7:0]        tag_q, tag_d;

    // NOTE: every always_comb output gets its hold value first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        tag_d   = tag_q;
        if (wr_en) begin
            for (int k = 0; k < IMG_D; k++) begin
                line_d[(k * IMG_W + int'(wr_col)) * DATA_WIDTH +: DATA_WIDTH] =
                    wr_data[k * DATA_WIDTH +: DATA_WIDTH];
            end
            if (wr_col == '0) begin
                tag_d   = tag_in;
                state_d = FILLING;
            end
            if (wr_close) state_d = FULL;
        end
        if (rd_free) state_d = EMPTY;
    end

    // NOTE: the line store is plain flops, not a RAM, so it is reset to give an all-zero line_data out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
            line_q  <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            tag_q   <= tag_d;
        end
    end

    assign state   = state_q;
    assign tag_out = tag_q;

`ifdef CONV_LINE_PACKER_ZERO_PAD_EN
    logic [COL_ADDR_WIDTH:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (wr_en && wr_close) cnt_d = (COL_ADDR_WIDTH + 1)'(wr_col) + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    // Short lines keep stale samples in storage; hide them on the way out.
    always_comb begin
        line_out = line_q;
        for (int k = 0; k < IMG_D; k++) begin
            for (int w = 0; w < IMG_W; w++) begin
                if (w >= int'(cnt_q)) line_out[(k * IMG_W + w) * DATA_WIDTH +: DATA_WIDTH] = '0;
            end
        end
    end
`else
    assign line_out = line_q;
`endif

endmodule

// File: rtl/conv_line_packer_1d.sv
// Double-buffered column-to-line packer feeding the parallel 1-D conv array.
// Optional early line close on pix_last: define CONV_LINE_PACKER_ZERO_PAD_EN.
module conv_line_packer_1d
    import conv_1d_pkg::*;
#(
    parameter  int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter  int IMG_W          = IMG_W_DEF,
    parameter  int IMG_D          = IMG_D_DEF,
    localparam int COL_ADDR_WIDTH = $clog2(IMG_W),
    localparam int COL_W          = DATA_WIDTH * IMG_D,
    localparam int LINE_W         = COL_W * IMG_W
) (
    input  logic                   clk,
    input  logic                   reset,
    conv_line_packer_1d_if.slave   bus
);

    localparam logic [COL_ADDR_WIDTH-1:0] LAST_COL = COL_ADDR_WIDTH'(IMG_W - 1);

    logic                      wr_bank_q, wr_bank_d;
    logic                      rd_bank_q, rd_bank_d;
    logic [COL_ADDR_WIDTH-1:0] col_q, col_d;

    bank_state_t       bank_state [2];
    logic [LINE_W-1:0] bank_line  [2];
    logic [7:0]        bank_tag   [2];

    logic       pix_ready, line_valid;
    logic       accept, handshake, close;
    logic [1:0] wr_en, rd_free;

    // Ready depends only on registered bank state, never on line_ready.
    assign pix_ready  = (bank_state[wr_bank_q] != FULL);
    assign line_valid = (bank_state[rd_bank_q] == FULL);
    assign accept     = bus.pix_valid && pix_ready;
    assign handshake  = line_valid && bus.line_ready;

`ifdef CONV_LINE_PACKER_ZERO_PAD_EN
    assign close = accept && ((col_q == LAST_COL) || bus.pix_last);
`else
    logic unused_pix_last;
    assign unused_pix_last = bus.pix_last;
    assign close = accept && (col_q == LAST_COL);
`endif

    always_comb begin
        wr_en              = '0;
        wr_en[wr_bank_q]   = accept;
        rd_free            = '0;
        rd_free[rd_bank_q] = handshake;
        col_d              = col_q;
        wr_bank_d          = wr_bank_q;
        rd_bank_d          = rd_bank_q;
        if (close) begin
            col_d     = '0;
            wr_bank_d = ~wr_bank_q;
        end else if (accept) begin
            col_d = col_q + COL_ADDR_WIDTH'(1);
        end
        if (handshake) rd_bank_d = ~rd_bank_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            col_q     <= '0;
        end else begin
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            col_q     <= col_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        conv_line_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .IMG_W      (IMG_W),
            .IMG_D      (IMG_D)
        ) u_bank (
            .clk      (clk),
            .reset    (reset),
            .wr_en    (wr_en[b]),
            .wr_col   (col_q),
            .wr_data  (bus.pix_data),
            .tag_in   (bus.opaque_in),
            .wr_close (close),
            .rd_free  (rd_free[b]),
            .state    (bank_state[b]),
            .line_out (bank_line[b]),
            .tag_out  (bank_tag[b])
        );
    end

    assign bus.pix_ready  = pix_ready;
    assign bus.line_valid = line_valid;
    assign bus.line_data  = bank_line[rd_bank_q];
    assign bus.opaque_out = bank_tag[rd_bank_q];

endmodule

// File: tb/tb_conv_line_packer_1d.sv
// Self-checking bench for conv_line_packer_1d: queue-of-lines model plus directed literal checks.
`timescale 1ns/1ps
module tb_conv_line_packer_1d;
    import conv_1d_pkg::*;

    localparam int DW = DATA_WIDTH_DEF;
    localparam int W  = IMG_W_DEF;
    localparam int D  = IMG_D_DEF;
    localparam int CB = COL_BITS;
    localparam int LB = LINE_BITS;

    typedef struct {
        logic [CB-1:0] data;
        logic          last;
        logic [7:0]    tag;
    } beat_t;

    typedef struct {
        logic [LB-1:0] data;
        logic [7:0]    tag;
    } line_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    conv_line_packer_1d_if #(.DATA_WIDTH(DW), .IMG_W(W), .IMG_D(D)) bus ();

    conv_line_packer_1d #(.DATA_WIDTH(DW), .IMG_W(W), .IMG_D(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    beat_t         beats [$];
    line_t         pend  [$];
    logic [CB-1:0] m_cols [W];
    int            m_col    = 0;
    logic [7:0]    m_tag    = '0;
    bit            acc_flag = 1'b0;
    int            acc_cnt  = 0;
    bit            vrand    = 1'b0;
    bit            lr_rand  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_line(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
        bit shown;
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            shown = 1'b0;
            for (int i = 0; i < LB / DW; i++) begin
                if (!shown && act[i*DW +: DW] !== exp[i*DW +: DW]) begin
                    $display("FAIL %s: ch %0d col %0d got 0x%0h expected 0x%0h at %0t",
                             name, i / W, i % W, act[i*DW +: DW], exp[i*DW +: DW], $time);
                    shown = 1'b1;
                end
            end
        end
    endtask

    function automatic logic [7:0] byte_at(input logic [LB-1:0] ln, input int k, input int w);
        return ln[(k * W + w) * DW +: DW];
    endfunction

    task automatic push(input logic [CB-1:0] d, input logic last, input logic [7:0] tag);
        beat_t b;
        b.data = d;
        b.last = last;
        b.tag  = tag;
        beats.push_back(b);
    endtask

    task automatic wait_acc(input int target, input string name);
        int n;
        n = 0;
        while (acc_cnt < target && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(acc_cnt >= target), 32'd1);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while ((beats.size() > 0 || pend.size() > 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(beats.size() == 0 && pend.size() == 0), 32'd1);
    endtask

    // Model: a line becomes pending when its closing beat is accepted; the
    // packer accepts while fewer than two lines are pending and presents the oldest.
    initial begin : model
        bit    acc, hs, fin;
        line_t ln;
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                pend.delete();
                m_col    = 0;
                acc_flag = 1'b0;
            end else begin
                acc      = bus.pix_valid && (pend.size() < 2);
                hs       = bus.line_ready && (pend.size() > 0);
                acc_flag = acc;
                if (hs) pend.delete(0);
                if (acc) begin
                    acc_cnt++;
                    if (m_col == 0) m_tag = bus.opaque_in;
                    m_cols[m_col] = bus.pix_data;
                    fin = (m_col == W - 1);
`ifdef CONV_LINE_PACKER_ZERO_PAD_EN
                    fin = fin || bus.pix_last;
`endif
                    if (fin) begin
                        ln.data = '0;
                        for (int w = 0; w <= m_col; w++)
                            for (int k = 0; k < D; k++)
                                ln.data[(k * W + w) * DW +: DW] = m_cols[w][k * DW +: DW];
                        ln.tag = m_tag;
                        pend.push_back(ln);
                        m_col = 0;
                    end else begin
                        m_col++;
                    end
                end
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (reset) begin
                check("pix_ready", 32'(bus.pix_ready), 32'(pend.size() < 2));
                check("line_valid", 32'(bus.line_valid), 32'(pend.size() > 0));
                if (pend.size() > 0) begin
                    check_line("line_data", bus.line_data, pend[0].data);
                    check("opaque_out", 32'(bus.opaque_out), 32'(pend[0].tag));
                end
            end
        end
    end

    initial begin : drive
        bus.pix_valid  = 1'b0;
        bus.pix_data   = '0;
        bus.pix_last   = 1'b0;
        bus.opaque_in  = '0;
        bus.line_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (acc_flag && beats.size() > 0) beats.delete(0);
            if (reset && beats.size() > 0) begin
                bus.pix_valid = vrand ? ($urandom_range(7) != 0) : 1'b1;
                bus.pix_data  = beats[0].data;
                bus.pix_last  = beats[0].last;
                bus.opaque_in = beats[0].tag;
            end else begin
                bus.pix_valid = 1'b0;
                bus.pix_last  = 1'b0;
            end
            if (lr_rand) bus.line_ready = ($urandom_range(1) == 1);
        end
    end

    initial begin : watchdog
        #950000;
        $display("FAIL watchdog: got no completion expected summary before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int base;
        int len;

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_line_valid", 32'(bus.line_valid), 32'd0);
        check("rst_opaque_out", 32'(bus.opaque_out), 32'd0);
        check_line("rst_line_data", bus.line_data, '0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_pix_ready", 32'(bus.pix_ready), 32'd1);

        // Single line, column w carries byte w in every channel.
        bus.line_ready = 1'b1;
        base = acc_cnt;
        for (int w = 0; w < W; w++) push({D{8'(w)}}, 1'b0, (w == 0) ? 8'hA5 : 8'(w) ^ 8'h3C);
        wait_acc(base + W, "t1_acc");
        check("t1_valid_next_cycle", 32'(bus.line_valid), 32'd1);
        check("t1_tag", 32'(bus.opaque_out), 32'hA5);
        check("t1_k0_w0", 32'(byte_at(bus.line_data, 0, 0)), 32'd0);
        check("t1_k3_w5", 32'(byte_at(bus.line_data, 3, 5)), 32'd5);
        check("t1_k7_w31", 32'(byte_at(bus.line_data, 7, 31)), 32'd31);
        @(negedge clk);
        check("t1_taken", 32'(bus.line_valid), 32'd0);

        // Three lines with the consumer stalled: both banks fill, input stalls.
        bus.line_ready = 1'b0;
        base = acc_cnt;
        for (int l = 0; l < 3; l++)
            for (int w = 0; w < W; w++)
                push({D{8'(l * 64 + w)}}, 1'b0, (w == 0) ? 8'(8'h11 * (l + 1)) : 8'hEE);
        wait_acc(base + 2 * W, "t2_acc64");
        repeat (3) @(negedge clk);
        check("t2_stalled_ready", 32'(bus.pix_ready), 32'd0);
        check("t2_held_valid", 32'(bus.line_valid), 32'd1);
        check("t2_held_tag", 32'(bus.opaque_out), 32'h11);
        bus.line_ready = 1'b1;
        @(negedge clk);
        check("t2_ready_after_hs", 32'(bus.pix_ready), 32'd1);
        check("t2_second_tag", 32'(bus.opaque_out), 32'h22);
        wait_idle(400, "t2_drain");

        // Line 2 closes in the same cycle line 1 is handed over.
        bus.line_ready = 1'b0;
        base = acc_cnt;
        for (int l = 0; l < 2; l++)
            for (int w = 0; w < W; w++)
                push({D{8'(8'h80 + l * 32 + w)}}, 1'b0, (w == 0) ? 8'(8'h44 + l * 8'h11) : 8'h00);
        wait_acc(base + 2 * W - 1, "t3_acc63");
        bus.line_ready = 1'b1;
        @(negedge clk);
        check("t3_no_gap_valid", 32'(bus.line_valid), 32'd1);
        check("t3_no_gap_tag", 32'(bus.opaque_out), 32'h55);
        check("t3_last_col", 32'(byte_at(bus.line_data, 4, 31)), 32'hBF);
        @(negedge clk);
        check("t3_drained", 32'(bus.line_valid), 32'd0);

        // Reset in the middle of a line discards it.
        base = acc_cnt;
        for (int w = 0; w < W; w++) push({D{8'(8'hC0 + w)}}, 1'b0, 8'h12);
        wait_acc(base + 10, "t4_acc10");
        @(posedge clk);
        #2;
        reset = 1'b0;
        beats.delete();
        @(negedge clk);
        check("t4_rst_valid", 32'(bus.line_valid), 32'd0);
        check("t4_rst_tag", 32'(bus.opaque_out), 32'd0);
        check_line("t4_rst_data", bus.line_data, '0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t4_ready_after_rst", 32'(bus.pix_ready), 32'd1);
        check("t4_no_line", 32'(bus.line_valid), 32'd0);
        base = acc_cnt;
        for (int w = 0; w < W; w++) push({D{8'(8'h40 + w)}}, 1'b0, (w == 0) ? 8'h77 : 8'h12);
        wait_acc(base + W, "t4_fresh_acc");
        check("t4_fresh_valid", 32'(bus.line_valid), 32'd1);
        check("t4_fresh_tag", 32'(bus.opaque_out), 32'h77);
        check("t4_fresh_col0", 32'(byte_at(bus.line_data, 2, 0)), 32'h40);
        wait_idle(200, "t4_drain");

        // pix_last on column 19.
        bus.line_ready = 1'b0;
        base = acc_cnt;
        for (int w = 0; w < 20; w++) push({D{8'hFF}}, (w == 19), (w == 0) ? 8'h99 : 8'h01);
        for (int w = 0; w < 12; w++) push({D{8'h5A}}, (w == 11), (w == 0) ? 8'h66 : 8'h02);
`ifdef CONV_LINE_PACKER_ZERO_PAD_EN
        wait_acc(base + 20, "t5_acc20");
        check("t5_early_valid", 32'(bus.line_valid), 32'd1);
        check("t5_early_tag", 32'(bus.opaque_out), 32'h99);
        check("t5_col19", 32'(byte_at(bus.line_data, 0, 19)), 32'hFF);
        check("t5_col20_zero", 32'(byte_at(bus.line_data, 7, 20)), 32'h00);
        check("t5_col31_zero", 32'(byte_at(bus.line_data, 3, 31)), 32'h00);
`else
        wait_acc(base + 20, "t5_acc20");
        check("t5_not_closed", 32'(bus.line_valid), 32'd0);
        wait_acc(base + 32, "t5_acc32");
        check("t5_full_valid", 32'(bus.line_valid), 32'd1);
        check("t5_tag", 32'(bus.opaque_out), 32'h99);
        check("t5_col19", 32'(byte_at(bus.line_data, 0, 19)), 32'hFF);
        check("t5_col20", 32'(byte_at(bus.line_data, 7, 20)), 32'h5A);
`endif
        bus.line_ready = 1'b1;
        wait_idle(200, "t5_drain");

        // Randomised valid/ready traffic over many lines.
        for (int l = 0; l < 1000; l++) begin
`ifdef CONV_LINE_PACKER_ZERO_PAD_EN
            len = ($urandom_range(7) == 0) ? int'($urandom_range(W, 1)) : W;
            for (int w = 0; w < len; w++)
                push({$urandom, $urandom}, (w == len - 1), 8'($urandom));
`else
            len = W;
            for (int w = 0; w < len; w++)
                push({$urandom, $urandom}, ($urandom_range(15) == 0), 8'($urandom));
`endif
        end
        vrand   = 1'b1;
        lr_rand = 1'b1;
        wait_idle(60000, "t6_drain");
        vrand   = 1'b0;
        lr_rand = 1'b0;
        @(negedge clk);
        bus.line_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("end_idle_valid", 32'(bus.line_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
